// File: rtl/grf_wb_arbiter.sv
// GRF writeback arbiter: port A (never stalled) always wins; port B results queue in a squashing FIFO.
// Latency: A 0 cycles, B >= 1 cycle (0 when GRF_WB_BYPASS_EN bypasses an empty queue). Backpressure: b_ready low when queue full.
module grf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic [31:0] b_pc,
    output logic        WE,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] PC,
    input  logic [4:0]  rq_addr1,
    input  logic [4:0]  rq_addr2,
    output logic        rq_hit1,
    output logic        rq_hit2
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]    addr_q [DEPTH];
    logic [4:0]    addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   pc_d   [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic a_wr, b_nz, empty, head_live, byp, push, pop;

    always_comb begin
        a_wr      = a_valid && (a_addr != 5'd0);
        empty     = (cnt_q == '0);
        head_live = !empty && live_q[head_q];
        b_ready   = reset && (cnt_q < FULL);
        b_nz      = b_valid && b_ready && (b_addr != 5'd0);
`ifdef GRF_WB_BYPASS_EN
        byp       = b_nz && empty && !a_wr;
`else
        byp       = 1'b0;
`endif
        push      = b_nz && !byp;
        // Dead heads drain every cycle; live heads only when A leaves the write port free.
        pop       = !empty && (!live_q[head_q] || !a_wr);

        WE = 1'b0;
        A3 = 5'd0;
        WD = 32'd0;
        PC = 32'd0;
        if (a_wr) begin
            WE = 1'b1; A3 = a_addr; WD = a_data; PC = a_pc;
        end else if (head_live) begin
            WE = 1'b1; A3 = addr_q[head_q]; WD = data_q[head_q]; PC = pc_q[head_q];
        end else if (byp) begin
            WE = 1'b1; A3 = b_addr; WD = b_data; PC = b_pc;
        end
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        pc_d   = pc_q;
        live_d = live_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        // An A write makes older queued results to the same register stale.
        for (int i = 0; i < DEPTH; i++) begin
            if (a_wr && (addr_q[i] == a_addr)) live_d[i] = 1'b0;
        end
        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = head_q + AW'(1);
        end
        if (push) begin
            addr_d[tail_q] = b_addr;
            data_d[tail_q] = b_data;
            pc_d[tail_q]   = b_pc;
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + AW'(1);
        end
    end

    // Live bits are cleared on pop, so live implies the entry is still queued.
    always_comb begin
        rq_hit1 = 1'b0;
        rq_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == rq_addr1)) rq_hit1 = 1'b1;
            if (live_q[i] && (addr_q[i] == rq_addr2)) rq_hit2 = 1'b1;
        end
        rq_hit1 = rq_hit1 && reset && (rq_addr1 != 5'd0);
        rq_hit2 = rq_hit2 && reset && (rq_addr2 != 5'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
            live_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
                pc_q[i]   <= pc_d[i];
            end
            live_q <= live_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of port-B queue entries (power of two, 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port A (pipeline writeback, never stalled): a_valid in 1, a_addr in 5, a_data in 32, a_pc in 32.
REQ-005 The block SHALL have port B (multi-cycle unit result, valid/ready): b_valid in 1, b_ready out 1, b_addr in 5, b_data in 32, b_pc in 32.
REQ-006 The block SHALL have the GRF write side: WE out 1, A3 out 5, WD out 32, PC out 32.
REQ-007 The block SHALL have pending query ports rq_addr1 in 5, rq_addr2 in 5, rq_hit1 out 1, rq_hit2 out 1 (combinational, for decode-stage stall).

Function
REQ-008 The block SHALL drive at most one GRF write per cycle.
REQ-009 Port-A write requests SHALL always have priority: when a_valid=1 and a_addr!=0, WE=1, A3=a_addr, WD=a_data and PC=a_pc, combinationally in the same cycle.
REQ-010 Port-B transfer SHALL occur when b_valid=1 and b_ready=1; b_ready=1 SHALL hold exactly when the queue occupancy is below DEPTH (registered state only, independent of b_valid).
REQ-011 A port-B transfer with b_addr=0 SHALL be accepted and discarded (no enqueue, no write); an A request with a_addr=0 SHALL produce WE=0.
REQ-012 An accepted nonzero port-B transfer SHALL enqueue {addr,data,pc,live=1} at the tail; the queue SHALL be FIFO with wrap-around pointers and an occupancy counter of width log2(DEPTH)+1.
REQ-013 When port A is not writing and the head entry is live, the head SHALL drive WE/A3/WD/PC and SHALL be popped at the clock edge.
REQ-014 A dead head entry SHALL be popped in any cycle, including cycles where A writes, without asserting WE.
REQ-015 Squash rule: an A write to address X SHALL clear live on every queued entry with addr X at the same edge; a B entry enqueued in that same cycle with addr X SHALL stay live (it is younger).
REQ-016 Simultaneous push and pop SHALL leave occupancy unchanged; push at DEPTH cannot occur because b_ready=0.
REQ-017 rq_hitN SHALL be 1 iff rq_addrN!=0 and some queued live entry has addr=rq_addrN; entries accepted in the current cycle SHALL be excluded.
REQ-018 When no write is issued, WE=0, A3=0, WD=0 and PC=0.
REQ-019 Minimum port-B latency SHALL be one cycle from acceptance to WE (without bypass, REQ-025).

Reset
REQ-020 Assertion of reset (low) SHALL immediately clear occupancy, head/tail pointers and all live bits, regardless of clock.
REQ-021 During reset, b_ready=0, rq_hit1=rq_hit2=0, and WE/A3/WD/PC SHALL be 0 unless port A requests a write, A being combinational.
REQ-022 Reset mid-operation SHALL discard all queued entries; none are written afterward.
REQ-023 After reset deasserts, b_ready SHALL be 1 on the first clock edge.

Configuration
REQ-024 The macro GRF_WB_BYPASS_EN SHALL select the port-B bypass path.
REQ-025 With GRF_WB_BYPASS_EN defined: a nonzero B transfer arriving while the queue is empty and port A is not writing SHALL drive WE/A3/WD/PC combinationally in the same cycle and SHALL NOT be enqueued.
REQ-026 Without GRF_WB_BYPASS_EN: every nonzero B transfer SHALL be enqueued, with latency per REQ-019.

Verification
REQ-027 Reset low, then A writes $5=0x1234 pc=0x3000 -> WE=1, A3=5, WD=0x1234 same cycle; b_ready=1 one edge after release.
REQ-028 Four B pushes $8..$11 while A writes every cycle -> b_ready=0 at occupancy 4; rq_hit for 8..11 =1; A idle -> $8,$9,$10,$11 written on 4 consecutive cycles.
REQ-029 Queue holds $9=0xAA; A writes $9=0xBB -> rq_hit(9)=0 next cycle; the dead entry is popped with no second $9 write.
REQ-030 B push $0=0xFFFF -> no enqueue, occupancy stays 0, never WE with A3=0.
REQ-031 Bypass: empty queue, A idle, B push $3=0x77 -> WE same cycle with the macro, next cycle without it.
REQ-032 Queue holds 3 entries, reset pulsed low mid-cycle -> b_ready=0 at once; after release no queued write ever appears.
